// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: fetch FSM encoding, word-address type
// and the instruction-register reset value.
package cpu_pkg;

    localparam int WA_W = 30;

    localparam logic [31:0] IR_RESET_DEFAULT = 32'h0000_0000;

    typedef logic [WA_W-1:0] waddr_t;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus bundle: instruction-memory read handshake plus the
// IR valid/ready hand-off towards decode.
interface ifetch_ctrl_if;
    import cpu_pkg::*;

    logic        imem_req;
    waddr_t      imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic        ir_ready;
    logic [31:0] IR;
    waddr_t      ir_pc;

    modport master (
        output imem_req, imem_addr, ir_valid, IR, ir_pc,
        input  imem_ack, imem_rdata, ir_ready
    );

    modport slave (
        input  imem_req, imem_addr, ir_valid, IR, ir_pc,
        output imem_ack, imem_rdata, ir_ready
    );

endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: issues one word read per instruction,
// holds the result in IR until decode takes it, and steers the PC register
// (sequential increment or branch/jump redirect). A redirect that lands
// while a read is outstanding sends the FSM to S_DRAIN so the stale
// response is swallowed instead of reaching IR.
module ifetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] IR_RESET = IR_RESET_DEFAULT,
    parameter waddr_t      PC_INC   = waddr_t'(1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  waddr_t       PC,
    output waddr_t       NPC,
    output logic         PCWr,
    input  logic         redirect,
    input  waddr_t       redirect_target,
    ifetch_ctrl_if.master bus
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic         r_req;
    logic         w_req_nxt;
    waddr_t       r_addr;
    waddr_t       w_addr_nxt;
    logic [31:0]  r_ir;
    waddr_t       r_ir_pc;

    logic         w_ack;
    logic         w_pcwr;
    waddr_t       w_npc;
    waddr_t       w_seq_pc;
    logic         w_capture;
    logic         w_squash;

    // An ack only means something while our own request is on the bus.
    assign w_ack    = bus.imem_ack & r_req;
    assign w_seq_pc = PC + PC_INC;

    // Next-state, request launch and PC-steering decisions; redirect always wins.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_addr_nxt  = r_addr;
        w_pcwr      = 1'b0;
        w_npc       = w_seq_pc;
        w_capture   = 1'b0;
        w_squash    = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (redirect) begin
                    w_pcwr = 1'b1;
                    w_npc  = redirect_target;
                    if (w_ack) begin
                        // Response arrives with the redirect: drop it, refetch from target.
                        w_req_nxt = 1'b0;
                    end else if (r_req) begin
                        // Request in flight: keep it up until the memory answers.
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_req_nxt  = 1'b1;
                        w_addr_nxt = redirect_target;
                    end
                end else if (w_ack) begin
                    w_pcwr      = 1'b1;
                    w_capture   = 1'b1;
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_HOLD;
                end else if (!r_req) begin
                    // Idle cycle after reset or after a discarded response.
                    w_req_nxt  = 1'b1;
                    w_addr_nxt = PC;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_pcwr      = 1'b1;
                    w_npc       = redirect_target;
                    w_squash    = 1'b1;
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = redirect_target;
                    w_state_nxt = S_FETCH;
                end else if (bus.ir_ready) begin
                    // PC was already advanced when this instruction was captured.
                    w_req_nxt   = 1'b1;
                    w_addr_nxt  = PC;
                    w_state_nxt = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (redirect) begin
                    w_pcwr = 1'b1;
                    w_npc  = redirect_target;
                end
                if (w_ack) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = S_FETCH;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_state_nxt = S_FETCH;
            end
        endcase
    end

    // FSM state plus the registered request level and its held address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_req   <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_addr  <= w_addr_nxt;
        end
    end

    // Instruction register and its PC; cleared when a held instruction is squashed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir    <= IR_RESET;
            r_ir_pc <= '0;
        end else if (w_capture) begin
            r_ir    <= bus.imem_rdata;
            r_ir_pc <= PC;
        end else if (w_squash) begin
            r_ir    <= IR_RESET;
        end
    end

    // The PC register must see a plain sequential NPC and no write while in reset.
    assign PCWr = rst_n & w_pcwr;
    assign NPC  = rst_n ? w_npc : w_seq_pc;

    assign bus.imem_req  = r_req;
    assign bus.imem_addr = r_addr;
    assign bus.ir_valid  = (r_state == S_HOLD);
    assign bus.IR        = r_ir;
    assign bus.ir_pc     = r_ir_pc;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Bench for ifetch_ctrl: directed scenarios followed by a randomized run.
// The reference model tracks the fetch unit as a handful of flags
// (request outstanding, response to be discarded, instruction held) and
// owns the PC register, which it updates from its own expected NPC/PCWr.
module tb_ifetch_ctrl;
    import cpu_pkg::*;

    logic   clk;
    logic   rst_n;
    waddr_t PC;
    waddr_t NPC;
    logic   PCWr;
    logic   redirect;
    waddr_t redirect_target;

    ifetch_ctrl_if bus ();

    ifetch_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .PC              (PC),
        .NPC             (NPC),
        .PCWr            (PCWr),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .bus             (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic        m_req;
    waddr_t      m_addr;
    logic        m_stale;
    logic        m_valid;
    logic [31:0] m_ir;
    waddr_t      m_irpc;

    // Auto-responder state for the randomized phase
    logic in_req;
    int   wcnt;

    function automatic logic [31:0] mem_word(input waddr_t a);
        if (a == '0) return 32'h2008_0005;
        return {2'b10, a} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check against the model, clock, advance the model.
    task automatic step(input logic ack, input logic rdy, input logic rd, input waddr_t tgt);
        logic   e_pcwr;
        logic   e_ack;
        waddr_t e_npc;
        waddr_t old_pc;
        bus.imem_ack    = ack;
        bus.imem_rdata  = mem_word(bus.imem_addr);
        bus.ir_ready    = rdy;
        redirect        = rd;
        redirect_target = tgt;
        #1;
        e_ack  = ack && m_req;
        e_npc  = PC + 30'd1;
        e_pcwr = 1'b0;
        if (rd) begin
            e_pcwr = 1'b1;
            e_npc  = tgt;
        end else if (!m_valid && e_ack && !m_stale) begin
            e_pcwr = 1'b1;
        end
        chk("imem_req", {31'b0, bus.imem_req}, {31'b0, m_req});
        if (m_req) chk("imem_addr", {2'b0, bus.imem_addr}, {2'b0, m_addr});
        chk("ir_valid", {31'b0, bus.ir_valid}, {31'b0, m_valid});
        if (m_valid) begin
            chk("IR", bus.IR, m_ir);
            chk("ir_pc", {2'b0, bus.ir_pc}, {2'b0, m_irpc});
        end
        chk("PCWr", {31'b0, PCWr}, {31'b0, e_pcwr});
        chk("NPC", {2'b0, NPC}, {2'b0, e_npc});
        @(posedge clk);
        #1;
        old_pc = PC;
        if (e_pcwr) PC = e_npc;
        if (m_valid) begin
            if (rd || rdy) begin
                m_valid = 1'b0;
                m_req   = 1'b1;
                m_addr  = PC;
            end
        end else if (e_ack) begin
            if (!m_stale && !rd) begin
                m_valid = 1'b1;
                m_ir    = mem_word(m_addr);
                m_irpc  = old_pc;
            end
            m_req   = 1'b0;
            m_stale = 1'b0;
        end else if (m_req) begin
            if (rd) m_stale = 1'b1;
        end else begin
            m_req  = 1'b1;
            m_addr = PC;
        end
    endtask

    // Asynchronous reset mid-cycle, checked before any clock edge, then release.
    task automatic do_reset(input waddr_t pc_at_release);
        #2;
        redirect        = 1'b1;
        redirect_target = 30'h155;
        rst_n           = 1'b0;
        #1;
        chk("rst_imem_req", {31'b0, bus.imem_req}, 32'd0);
        chk("rst_ir_valid", {31'b0, bus.ir_valid}, 32'd0);
        chk("rst_IR", bus.IR, 32'h0000_0000);
        chk("rst_ir_pc", {2'b0, bus.ir_pc}, 32'd0);
        chk("rst_PCWr", {31'b0, PCWr}, 32'd0);
        chk("rst_NPC", {2'b0, NPC}, {2'b0, PC + 30'd1});
        redirect     = 1'b0;
        bus.imem_ack = 1'b0;
        bus.ir_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        PC      = pc_at_release;
        rst_n   = 1'b1;
        m_req   = 1'b0;
        m_addr  = '0;
        m_stale = 1'b0;
        m_valid = 1'b0;
        m_ir    = 32'h0;
        m_irpc  = '0;
        in_req  = 1'b0;
        wcnt    = 0;
    endtask

    initial begin
        logic   a;
        logic   r;
        logic   d;
        waddr_t t;
        rst_n              = 1'b0;
        PC                 = '0;
        redirect           = 1'b0;
        redirect_target    = '0;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.ir_ready       = 1'b0;

        // Reset release with a zero-wait memory at PC 0
        do_reset(30'h0);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("t1_IR", bus.IR, 32'h2008_0005);
        chk("t1_ir_valid", {31'b0, bus.ir_valid}, 32'd1);

        // Decode takes it; next fetch waits 3 cycles, then decode stalls 4 cycles
        step(1'b0, 1'b1, 1'b0, '0);
        repeat (3) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        repeat (4) step(1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);

        // Redirect while a read is outstanding; the ack arrives two cycles later
        step(1'b0, 1'b0, 1'b1, 30'h100);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("t3_addr", {2'b0, bus.imem_addr}, 32'h100);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("t3_IR", bus.IR, mem_word(30'h100));
        step(1'b0, 1'b1, 1'b0, '0);

        // Redirect in the same cycle as the ack
        step(1'b1, 1'b0, 1'b1, 30'h200);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        chk("t4_ir_pc", {2'b0, bus.ir_pc}, 32'h200);

        // Redirect together with ir_ready while holding an instruction
        step(1'b0, 1'b1, 1'b1, 30'h300);
        chk("t5_ir_valid", {31'b0, bus.ir_valid}, 32'd0);
        chk("t5_addr", {2'b0, bus.imem_addr}, 32'h300);

        // Reset while a request is up; then a fetch at the top word wraps NPC to 0
        do_reset(30'h3FFF_FFFF);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);

        // Reset while an instruction is held
        do_reset(30'h0);

        // Randomized traffic: variable memory latency, decode stalls, redirects
        for (int i = 0; i < 3000; i++) begin
            a = 1'b0;
            if (bus.imem_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wcnt   = int'($urandom_range(0, 3));
                end
                if (wcnt == 0) begin
                    a      = 1'b1;
                    in_req = 1'b0;
                end else begin
                    wcnt--;
                end
            end else begin
                in_req = 1'b0;
            end
            r = ($urandom_range(0, 1) == 1);
            d = ($urandom_range(0, 11) == 0);
            t = waddr_t'($urandom);
            step(a, r, d, t);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
